if_prefetch_unit: RTL and testbench
===================================

// Module: if_prefetch_unit
// PURPOSE
//  Parametrised instruction-fetch stage: owns the PC, issues pipelined IM requests
//  and buffers returned instructions in a DEPTH-entry queue that feeds ID via valid/ready.
//  Accepts two redirect sources (forwarded jump register, ID branch/jump target).
//  Redirects landing during STALL are held and applied later.
//  Sits between the IM port and the IF/ID register.
// PARAMETERS
//  ADDR_W       32            PC / address width
//  DATA_W       32            instruction width
//  RESET_VECTOR 32'hBFC00000  PC after reset (boot sequence start)
//  INC          4             PC increment per fetch
//  DEPTH        4             queue slots (power of 2, >=2)
//  MAX_OUTST    2             max IM requests granted but not yet returned (<=DEPTH)
// PORTS
//  CLOCK            in   1       clock, rising edge
//  RESET            in   1       asynchronous, active-low reset
//  STALL            in   1       global freeze of issue, pop and redirect apply
//  AltPC_IN         in   ADDR_W  branch/jump target from ID
//  AltPCEnable_IN   in   1       AltPC_IN valid this cycle
//  JumpReg_IN       in   ADDR_W  forwarded jump-register target
//  JumpFwd_IN       in   1       JumpReg_IN valid; wins over AltPCEnable_IN
//  IM_Req_OUT       out  1       fetch request
//  IM_Addr_OUT      out  ADDR_W  fetch address (= PC)
//  IM_Gnt_IN        in   1       request accepted this cycle
//  IM_RValid_IN     in   1       in-order response valid
//  IM_RData_IN      in   DATA_W  response instruction
//  ID_Valid_OUT     out  1       head slot filled
//  ID_Ready_IN      in   1       ID consumes head
//  ID_Instr_OUT     out  DATA_W  head instruction
//  ID_PC_OUT        out  ADDR_W  head address
//  ID_PCPlus4_OUT   out  ADDR_W  head address + INC (mod 2^ADDR_W)
// BEHAVIOUR
//  Reset: PC=RESET_VECTOR, queue empty, outstanding=0, discard=0, pending=0.
//   All outputs 0 except IM_Addr_OUT=RESET_VECTOR.
//  Issue: IM_Req_OUT = !STALL & !redirect_now & (count+outst)<DEPTH & outst<MAX_OUTST.
//   On Req&Gnt: reserve tail slot {addr=PC, filled=0}, PC<=PC+INC (wraps), outst++.
//  Response: if discard>0, drop and discard--.
//   Else fill the oldest unfilled reserved slot; outst-- in either case.
//   Responses are accepted even under STALL.
//  Pop: ID_Valid_OUT&ID_Ready_IN&!STALL -> head freed.
//   Same-cycle pop + reserve is legal when full.
//   Filled data is visible on ID_* from the cycle after IM_RValid_IN (registered, no bypass).
//  Redirect: target = JumpFwd_IN ? JumpReg_IN : AltPC_IN.
//   If STALL: latch into pending {flag,target}; the newest redirect overwrites.
//   redirect_now = (request without STALL) | (pending & !STALL).
//   A live input beats pending.
//   On redirect_now: PC<=target, all slots flushed, pending cleared.
//   discard <= outst - (response this cycle ? 1 : 0); a same-cycle response is dropped.
//   No request is issued in the redirect cycle; fetch resumes the next cycle.
//  Overlapping redirect while discard>0: add newly in-flight requests to discard.
//  Reset mid-operation clears all state immediately; IM is reset by the same RESET.
//  Inputs are never X-checked; IM_RValid_IN with outst=0 is a protocol error (assert).
// STRUCTURE
//  Package if_pkg: RESET_VECTOR default, INC, redirect-source enum {NONE,ALT,JFWD},
//   slot struct {addr, instr, filled}.
//  Sub-module if_fetch_queue:
//   - DEPTH slots, reserve/fill/pop/flush ports
//   - head/tail/fill pointers, count
//  Top: PC register, outstanding and discard counters, pending-redirect latch, issue logic.
// TESTING
//  1 Reset release, Gnt=1, RValid one cycle later, ID_Ready=1:
//     ID_PC_OUT sequence BFC00000, BFC00004, BFC00008; ID_PCPlus4_OUT = +4.
//  2 ID_Ready=0 for 10 cycles:
//     queue fills to DEPTH=4, IM_Req_OUT=0, PC=BFC00010, no slot overwritten.
//  3 AltPCEnable_IN=1, AltPC_IN=80000100 with 2 outstanding:
//     both responses dropped, next ID_PC_OUT=80000100.
//  4 JumpFwd_IN(00400020) and AltPCEnable_IN(00400040) in the same cycle:
//     PC=00400020.
//  5 Redirect 00001000 during a 3-cycle STALL, then a second redirect 00002000 still under STALL:
//     after release PC=00002000, no requests under STALL, responses still absorbed.
//  6 RESET low mid-burst with 2 outstanding:
//     outputs cleared in the same cycle, PC=BFC00000, first fetch after release at BFC00000.
//  7 PC=FFFFFFFC fetch:
//     next IM_Addr_OUT=00000000, ID_PCPlus4_OUT=00000000.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch prefetch unit.
// Holds the boot vector, PC step, redirect-source encoding and queue slot layout.
package if_pkg;

    localparam int PKG_ADDR_W = 32;
    localparam int PKG_DATA_W = 32;
    localparam logic [PKG_ADDR_W-1:0] PKG_RESET_VECTOR = 32'hBFC0_0000;
    localparam int PKG_INC = 4;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_ALT  = 2'd1,
        RD_JFWD = 2'd2
    } redir_src_e;

    typedef struct packed {
        logic [PKG_ADDR_W-1:0] addr;
        logic [PKG_DATA_W-1:0] instr;
        logic                  filled;
    } slot_t;

endpackage

// File: rtl/if_prefetch_unit_if.sv
// IM request/response bus and ID valid/ready bus of the fetch unit.
// master: fetch unit side; slave: memory + decode side.
interface if_prefetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              IM_Req_OUT;
    logic [ADDR_W-1:0] IM_Addr_OUT;
    logic              IM_Gnt_IN;
    logic              IM_RValid_IN;
    logic [DATA_W-1:0] IM_RData_IN;
    logic              ID_Valid_OUT;
    logic              ID_Ready_IN;
    logic [DATA_W-1:0] ID_Instr_OUT;
    logic [ADDR_W-1:0] ID_PC_OUT;
    logic [ADDR_W-1:0] ID_PCPlus4_OUT;

    modport master (
        output IM_Req_OUT,
        output IM_Addr_OUT,
        input  IM_Gnt_IN,
        input  IM_RValid_IN,
        input  IM_RData_IN,
        output ID_Valid_OUT,
        input  ID_Ready_IN,
        output ID_Instr_OUT,
        output ID_PC_OUT,
        output ID_PCPlus4_OUT
    );

    modport slave (
        input  IM_Req_OUT,
        input  IM_Addr_OUT,
        output IM_Gnt_IN,
        output IM_RValid_IN,
        output IM_RData_IN,
        input  ID_Valid_OUT,
        output ID_Ready_IN,
        input  ID_Instr_OUT,
        input  ID_PC_OUT,
        input  ID_PCPlus4_OUT
    );

endinterface

// File: rtl/if_fetch_queue.sv
// In-order fetch queue: slots are reserved at grant, filled at response, popped by ID.
// Ports: reserve (addr), fill (data), pop, flush; head addr/instr/valid and count out.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  flush_i,
    input  logic                  reserve_i,
    input  logic [PKG_ADDR_W-1:0] reserve_addr_i,
    input  logic                  fill_i,
    input  logic [PKG_DATA_W-1:0] fill_data_i,
    input  logic                  pop_i,
    output logic                  head_valid_o,
    output logic [PKG_ADDR_W-1:0] head_addr_o,
    output logic [PKG_DATA_W-1:0] head_instr_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);

    slot_t         slot_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] fptr_q, fptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_pop;

    assign head_addr_o  = slot_q[head_q].addr;
    assign head_instr_o = slot_q[head_q].instr;
    assign head_valid_o = (count_q != '0) && slot_q[head_q].filled;
    assign do_pop       = pop_i && head_valid_o;
    assign count_o      = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        fptr_d  = fptr_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            fptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_pop)    head_d = head_q + 1'b1;
            if (reserve_i) tail_d = tail_q + 1'b1;
            if (fill_i)    fptr_d = fptr_q + 1'b1;
            count_d = count_q
                    + {{PW{1'b0}}, reserve_i}
                    - {{PW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            head_q  <= '0;
            tail_q  <= '0;
            fptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i].addr   <= '0;
                slot_q[i].instr  <= '0;
                slot_q[i].filled <= 1'b0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            fptr_q  <= fptr_d;
            count_q <= count_d;
            if (flush_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    slot_q[i].filled <= 1'b0;
                end
            end else begin
                if (do_pop) begin
                    slot_q[head_q].filled <= 1'b0;
                end
                if (fill_i) begin
                    slot_q[fptr_q].instr  <= fill_data_i;
                    slot_q[fptr_q].filled <= 1'b1;
                end
                // Placed last: when full, a same-cycle pop frees the
                // very slot being reserved, and the reservation wins.
                if (reserve_i) begin
                    slot_q[tail_q].addr   <= reserve_addr_i;
                    slot_q[tail_q].instr  <= '0;
                    slot_q[tail_q].filled <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// Fetch stage: owns the PC, issues pipelined IM requests, queues returns for ID.
// Ports: CLOCK, RESET (async low), STALL, redirect inputs, bus (IM + ID, master).
module if_prefetch_unit
    import if_pkg::*;
#(
    parameter int                ADDR_W       = PKG_ADDR_W,
    parameter int                DATA_W       = PKG_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = PKG_RESET_VECTOR,
    parameter int                INC          = PKG_INC,
    parameter int                DEPTH        = 4,
    parameter int                MAX_OUTST    = 2
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               STALL,
    input  logic [ADDR_W-1:0]  AltPC_IN,
    input  logic               AltPCEnable_IN,
    input  logic [ADDR_W-1:0]  JumpReg_IN,
    input  logic               JumpFwd_IN,
    if_prefetch_unit_if.master bus
);

    localparam int OW = $clog2(MAX_OUTST + 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [OW-1:0]     outst_q, outst_d;
    logic [OW-1:0]     disc_q, disc_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] ptgt_q, ptgt_d;

    redir_src_e        src;
    logic              live;
    logic [ADDR_W-1:0] live_tgt;
    logic              redir_now;
    logic [ADDR_W-1:0] redir_tgt;
    logic              req;
    logic              grant;
    logic              rsp;
    logic              drop;
    logic              fill;

    logic              q_valid;
    logic [ADDR_W-1:0] q_addr;
    logic [DATA_W-1:0] q_instr;
    logic [$clog2(DEPTH):0] q_count;

    always_comb begin
        src = RD_NONE;
        if (JumpFwd_IN)          src = RD_JFWD;
        else if (AltPCEnable_IN) src = RD_ALT;
    end

    assign live     = (src != RD_NONE);
    assign live_tgt = (src == RD_JFWD) ? JumpReg_IN : AltPC_IN;

    // A redirect seen this cycle beats one parked during an earlier stall.
    assign redir_now = !STALL && (live || pend_q);
    assign redir_tgt = live ? live_tgt : ptgt_q;

    assign req = RESET && !STALL && !redir_now
              && ((int'(q_count) + int'(outst_q)) < DEPTH)
              && (int'(outst_q) < MAX_OUTST);
    assign grant = req && bus.IM_Gnt_IN;

    // Responses belonging to a flushed stream are dropped, including
    // one that lands in the redirect cycle itself.
    assign rsp  = bus.IM_RValid_IN;
    assign drop = rsp && (redir_now || (disc_q != '0));
    assign fill = rsp && !drop;

    always_comb begin
        pc_d    = pc_q;
        pend_d  = pend_q;
        ptgt_d  = ptgt_q;
        outst_d = outst_q + OW'(grant) - OW'(rsp);
        disc_d  = disc_q;
        if (redir_now) begin
            pc_d   = redir_tgt;
            pend_d = 1'b0;
            // Everything still in flight after this cycle is stale.
            disc_d = outst_q - OW'(rsp);
        end else begin
            if (grant) pc_d = pc_q + ADDR_W'(INC);
            if (rsp && (disc_q != '0)) disc_d = disc_q - 1'b1;
        end
        if (STALL && live) begin
            pend_d = 1'b1;
            ptgt_d = live_tgt;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            pc_q    <= RESET_VECTOR;
            outst_q <= '0;
            disc_q  <= '0;
            pend_q  <= 1'b0;
            ptgt_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            outst_q <= outst_d;
            disc_q  <= disc_d;
            pend_q  <= pend_d;
            ptgt_q  <= ptgt_d;
        end
    end

    if_fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .CLOCK          (CLOCK),
        .RESET          (RESET),
        .flush_i        (redir_now),
        .reserve_i      (grant),
        .reserve_addr_i (pc_q),
        .fill_i         (fill),
        .fill_data_i    (bus.IM_RData_IN),
        .pop_i          (bus.ID_Ready_IN && !STALL),
        .head_valid_o   (q_valid),
        .head_addr_o    (q_addr),
        .head_instr_o   (q_instr),
        .count_o        (q_count)
    );

    assign bus.IM_Req_OUT     = req;
    assign bus.IM_Addr_OUT    = pc_q;
    assign bus.ID_Valid_OUT   = q_valid;
    assign bus.ID_Instr_OUT   = q_valid ? q_instr : '0;
    assign bus.ID_PC_OUT      = q_valid ? q_addr : '0;
    assign bus.ID_PCPlus4_OUT = q_valid ? (q_addr + ADDR_W'(INC)) : '0;

    a_rvalid_outst: assert property (
        @(posedge CLOCK) disable iff (!RESET)
        bus.IM_RValid_IN |-> (outst_q != '0)
    );

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit: IM responder answering one cycle after grant,
// redirect/stall/reset scenarios checked with immediate assertions.
module tb_if_prefetch_unit;

    logic        CLOCK;
    logic        RESET;
    logic        STALL;
    logic [31:0] AltPC_IN;
    logic        AltPCEnable_IN;
    logic [31:0] JumpReg_IN;
    logic        JumpFwd_IN;

    if_prefetch_unit_if bus ();

    if_prefetch_unit dut (
        .CLOCK          (CLOCK),
        .RESET          (RESET),
        .STALL          (STALL),
        .AltPC_IN       (AltPC_IN),
        .AltPCEnable_IN (AltPCEnable_IN),
        .JumpReg_IN     (JumpReg_IN),
        .JumpFwd_IN     (JumpFwd_IN),
        .bus            (bus)
    );

    int          checks = 0;
    int          errors = 0;
    bit          resp_en;
    logic [31:0] rq [$];

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h",
                   tag, obs, exp);
        end
    endtask

    // Memory model: remembers granted addresses, answers in order
    // one cycle after the grant while resp_en is set.
    task automatic tick();
        #1;
        if (bus.IM_RValid_IN) void'(rq.pop_front());
        if (bus.IM_Req_OUT && bus.IM_Gnt_IN)
            rq.push_back(bus.IM_Addr_OUT);
        @(posedge CLOCK);
        #1;
        if (resp_en && rq.size() > 0) begin
            bus.IM_RValid_IN = 1'b1;
            bus.IM_RData_IN  = f(rq[0]);
        end else begin
            bus.IM_RValid_IN = 1'b0;
            bus.IM_RData_IN  = '0;
        end
    endtask

    task automatic apply_reset();
        RESET = 1'b0;
        rq.delete();
        bus.IM_RValid_IN = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
        #1;
    endtask

    task automatic head(input string tag, input logic [31:0] pc);
        chk({tag, "_v"},  32'(bus.ID_Valid_OUT), 32'd1);
        chk({tag, "_pc"}, bus.ID_PC_OUT, pc);
        chk({tag, "_p4"}, bus.ID_PCPlus4_OUT, pc + 32'd4);
        chk({tag, "_in"}, bus.ID_Instr_OUT, f(pc));
    endtask

    initial begin
        RESET            = 1'b0;
        STALL            = 1'b0;
        AltPC_IN         = '0;
        AltPCEnable_IN   = 1'b0;
        JumpReg_IN       = '0;
        JumpFwd_IN       = 1'b0;
        bus.IM_Gnt_IN    = 1'b1;
        bus.IM_RValid_IN = 1'b0;
        bus.IM_RData_IN  = '0;
        bus.ID_Ready_IN  = 1'b1;
        resp_en          = 1'b1;

        tick();
        tick();
        chk("rst_req",  32'(bus.IM_Req_OUT), 32'd0);
        chk("rst_addr", bus.IM_Addr_OUT, 32'hBFC0_0000);
        chk("rst_val",  32'(bus.ID_Valid_OUT), 32'd0);
        chk("rst_pc",   bus.ID_PC_OUT, 32'd0);
        chk("rst_p4",   bus.ID_PCPlus4_OUT, 32'd0);
        chk("rst_ins",  bus.ID_Instr_OUT, 32'd0);

        // Streaming fetch
        RESET = 1'b1;
        #1;
        chk("t1_req",  32'(bus.IM_Req_OUT), 32'd1);
        chk("t1_addr", bus.IM_Addr_OUT, 32'hBFC0_0000);
        tick();
        tick();
        head("t1_h0", 32'hBFC0_0000);
        tick();
        head("t1_h1", 32'hBFC0_0004);
        tick();
        head("t1_h2", 32'hBFC0_0008);

        // Back-pressure fills the queue
        bus.ID_Ready_IN = 1'b0;
        apply_reset();
        repeat (10) tick();
        chk("t2_req",  32'(bus.IM_Req_OUT), 32'd0);
        chk("t2_addr", bus.IM_Addr_OUT, 32'hBFC0_0010);
        head("t2_h0", 32'hBFC0_0000);
        bus.ID_Ready_IN = 1'b1;
        tick();
        chk("t2_h1", bus.ID_PC_OUT, 32'hBFC0_0004);
        tick();
        chk("t2_h2", bus.ID_PC_OUT, 32'hBFC0_0008);
        tick();
        head("t2_h3", 32'hBFC0_000C);

        // Redirect with two requests in flight
        resp_en = 1'b0;
        apply_reset();
        tick();
        tick();
        AltPC_IN       = 32'h8000_0100;
        AltPCEnable_IN = 1'b1;
        #1;
        chk("t3_req_rd", 32'(bus.IM_Req_OUT), 32'd0);
        tick();
        AltPCEnable_IN = 1'b0;
        resp_en        = 1'b1;
        #1;
        chk("t3_addr", bus.IM_Addr_OUT, 32'h8000_0100);
        tick();
        chk("t3_drop0", 32'(bus.ID_Valid_OUT), 32'd0);
        tick();
        chk("t3_drop1", 32'(bus.ID_Valid_OUT), 32'd0);
        chk("t3_req",   32'(bus.IM_Req_OUT), 32'd1);
        tick();
        chk("t3_wait", 32'(bus.ID_Valid_OUT), 32'd0);
        tick();
        head("t3_h0", 32'h8000_0100);

        // Forwarded jump register wins over ID target
        JumpReg_IN     = 32'h0040_0020;
        JumpFwd_IN     = 1'b1;
        AltPC_IN       = 32'h0040_0040;
        AltPCEnable_IN = 1'b1;
        #1;
        chk("t4_req_rd", 32'(bus.IM_Req_OUT), 32'd0);
        tick();
        JumpFwd_IN     = 1'b0;
        AltPCEnable_IN = 1'b0;
        #1;
        chk("t4_addr", bus.IM_Addr_OUT, 32'h0040_0020);
        chk("t4_req",  32'(bus.IM_Req_OUT), 32'd1);
        chk("t4_val",  32'(bus.ID_Valid_OUT), 32'd0);
        tick();
        tick();
        head("t4_h0", 32'h0040_0020);

        // Redirects under a 3-cycle stall; newest one is applied
        STALL          = 1'b1;
        AltPC_IN       = 32'h0000_1000;
        AltPCEnable_IN = 1'b1;
        #1;
        chk("t5_req0", 32'(bus.IM_Req_OUT), 32'd0);
        tick();
        AltPCEnable_IN = 1'b0;
        #1;
        chk("t5_req1",  32'(bus.IM_Req_OUT), 32'd0);
        chk("t5_addr1", bus.IM_Addr_OUT, 32'h0040_0028);
        chk("t5_hold",  bus.ID_PC_OUT, 32'h0040_0020);
        tick();
        AltPC_IN       = 32'h0000_2000;
        AltPCEnable_IN = 1'b1;
        #1;
        chk("t5_req2", 32'(bus.IM_Req_OUT), 32'd0);
        tick();
        AltPCEnable_IN = 1'b0;
        STALL          = 1'b0;
        #1;
        chk("t5_req3",  32'(bus.IM_Req_OUT), 32'd0);
        chk("t5_addr3", bus.IM_Addr_OUT, 32'h0040_0028);
        tick();
        chk("t5_addr", bus.IM_Addr_OUT, 32'h0000_2000);
        chk("t5_req",  32'(bus.IM_Req_OUT), 32'd1);
        tick();
        tick();
        head("t5_h0", 32'h0000_2000);

        // Asynchronous reset with two requests in flight
        resp_en = 1'b0;
        tick();
        bus.ID_Ready_IN = 1'b0;
        tick();
        chk("t6_req_pre", 32'(bus.IM_Req_OUT), 32'd0);
        chk("t6_pc_pre",  bus.ID_PC_OUT, 32'h0000_2004);
        RESET = 1'b0;
        #1;
        chk("t6_val",  32'(bus.ID_Valid_OUT), 32'd0);
        chk("t6_req",  32'(bus.IM_Req_OUT), 32'd0);
        chk("t6_addr", bus.IM_Addr_OUT, 32'hBFC0_0000);
        chk("t6_pc",   bus.ID_PC_OUT, 32'd0);
        chk("t6_p4",   bus.ID_PCPlus4_OUT, 32'd0);
        bus.ID_Ready_IN = 1'b1;
        resp_en         = 1'b1;
        apply_reset();
        chk("t6_req_post",  32'(bus.IM_Req_OUT), 32'd1);
        chk("t6_addr_post", bus.IM_Addr_OUT, 32'hBFC0_0000);
        tick();
        tick();
        head("t6_h0", 32'hBFC0_0000);

        // Address wrap at the top of the space
        AltPC_IN       = 32'hFFFF_FFFC;
        AltPCEnable_IN = 1'b1;
        #1;
        chk("t7_req_rd", 32'(bus.IM_Req_OUT), 32'd0);
        tick();
        AltPCEnable_IN = 1'b0;
        #1;
        chk("t7_addr0", bus.IM_Addr_OUT, 32'hFFFF_FFFC);
        chk("t7_req",   32'(bus.IM_Req_OUT), 32'd1);
        tick();
        chk("t7_addr1", bus.IM_Addr_OUT, 32'h0000_0000);
        tick();
        head("t7_h0", 32'hFFFF_FFFC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
